// File: rtl/viterbi_codec.sv
// -----------------------------------------------------------------------------
// viterbi_codec
//   Rate-1/2, K=3 convolutional encoder (generators 7,5 octal) and a
//   hard-decision Viterbi decoder with register-exchange survivors. The two
//   paths are independent and share only clk/rst.
//
// Parameters
//   TB_DEPTH  survivor depth in symbols (>= 8)
//   PM_W      path-metric width in bits (>= 4), metrics saturate at 2**PM_W-1
//
// Ports
//   clk           single clock, all logic on posedge
//   rst           synchronous, active-low reset
//   enc_enable_i  encoder input bit valid
//   enc_d_i       encoder data bit
//   enc_valid_o   enc_d_o valid (one cycle after an enabled edge)
//   enc_d_o[1:0]  coded symbol {g0,g1}
//   dec_enable_i  dec_d_i valid
//   dec_d_i[1:0]  received hard symbol, same bit order as enc_d_o
//   dec_valid_o   dec_d_o carries a decoded bit
//   dec_d_o       decoded bit, TB_DEPTH-1 accepted symbols behind the input
//   dec_err_o     (only with VITERBI_METRIC_OUT_EN) received symbol differed
//                 from the expected symbol of the winning branch
//
// Configuration
//   `define VITERBI_METRIC_OUT_EN to add the dec_err_o port and its logic.
// -----------------------------------------------------------------------------
module viterbi_codec #(
  parameter int TB_DEPTH = 16,
  parameter int PM_W     = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enc_enable_i,
  input  logic       enc_d_i,
  output logic       enc_valid_o,
  output logic [1:0] enc_d_o,
  input  logic       dec_enable_i,
  input  logic [1:0] dec_d_i,
  output logic       dec_valid_o,
  output logic       dec_d_o
`ifdef VITERBI_METRIC_OUT_EN
  ,
  output logic       dec_err_o
`endif
);

  localparam logic [PM_W-1:0]   PM_MAX    = {PM_W{1'b1}};
  localparam logic [PM_W-1:0]   PM_INIT   = PM_W'(8);
  localparam int                FILL_W    = $clog2(TB_DEPTH + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(TB_DEPTH);
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(TB_DEPTH - 1);

  // ---------------------------------------------------------------------------
  // Encoder: sr[1] is the most recent past bit, sr[0] the one before it.
  // ---------------------------------------------------------------------------
  logic [1:0] sr;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sr          <= 2'b00;
      enc_valid_o <= 1'b0;
      enc_d_o     <= 2'b00;
    end else begin
      enc_valid_o <= enc_enable_i;
      if (enc_enable_i) begin
        enc_d_o <= {enc_d_i ^ sr[1] ^ sr[0], enc_d_i ^ sr[0]};
        sr      <= {enc_d_i, sr[1]};
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Decoder state. The oldest survivor bit is only ever consumed
  // combinationally (it is the decoded output), so each stored survivor keeps
  // TB_DEPTH-1 bits and the full TB_DEPTH-bit path exists only in surv_new.
  // ---------------------------------------------------------------------------
  logic [PM_W-1:0]     pm       [4];
  logic [PM_W-1:0]     pm_new   [4];
  logic [PM_W-1:0]     acc      [4];
  logic [TB_DEPTH-2:0] surv     [4];
  logic [TB_DEPTH-1:0] surv_new [4];
`ifdef VITERBI_METRIC_OUT_EN
  logic [1:0]          win_bm   [4];
`endif
  logic [1:0]          best;
  logic [PM_W-1:0]     min_pm;
  logic [FILL_W-1:0]   fill;

  logic [1:0]  st, pu, pl, bm_u, bm_l;
  logic [PM_W:0] cand_u, cand_l, acc_raw;

  function automatic logic [1:0] hamming(input logic [1:0] a, input logic [1:0] b);
    return {1'b0, a[1] ^ b[1]} + {1'b0, a[0] ^ b[0]};
  endfunction

  // Add-compare-select, saturation, normalization and best-state search.
  // NOTE: every variable driven here gets a default first so no path through
  // the block can leave a value unassigned and infer a latch.
  always_comb begin
    st      = 2'b00;
    pu      = 2'b00;
    pl      = 2'b00;
    bm_u    = 2'b00;
    bm_l    = 2'b00;
    cand_u  = '0;
    cand_l  = '0;
    acc_raw = '0;
    min_pm  = PM_MAX;
    best    = 2'b00;
    for (int i = 0; i < 4; i++) begin
      acc[i]      = '0;
      pm_new[i]   = '0;
      surv_new[i] = '0;
`ifdef VITERBI_METRIC_OUT_EN
      win_bm[i]   = 2'b00;
`endif
    end

    for (int ns = 0; ns < 4; ns++) begin
      // ns = {b, x}; predecessors {x,0} (upper) and {x,1} (lower).
      st   = 2'(ns);
      pu   = {st[0], 1'b0};
      pl   = {st[0], 1'b1};
      // Expected {b^s1^s0, b^s0} with s1 = x and s0 = 0 or 1.
      bm_u = hamming(dec_d_i, {st[1] ^ st[0], st[1]});
      bm_l = hamming(dec_d_i, {~(st[1] ^ st[0]), ~st[1]});
      cand_u = {1'b0, pm[pu]} + {{(PM_W-1){1'b0}}, bm_u};
      cand_l = {1'b0, pm[pl]} + {{(PM_W-1){1'b0}}, bm_l};
      // Strict compare: a tie keeps the upper predecessor.
      if (cand_l < cand_u) begin
        acc_raw      = cand_l;
        surv_new[ns] = {surv[pl], st[1]};
`ifdef VITERBI_METRIC_OUT_EN
        win_bm[ns]   = bm_l;
`endif
      end else begin
        acc_raw      = cand_u;
        surv_new[ns] = {surv[pu], st[1]};
`ifdef VITERBI_METRIC_OUT_EN
        win_bm[ns]   = bm_u;
`endif
      end
      acc[ns] = (acc_raw > {1'b0, PM_MAX}) ? PM_MAX : acc_raw[PM_W-1:0];
    end

    // Strict compare: the lowest index wins a tie.
    for (int i = 0; i < 4; i++) begin
      if (acc[i] < min_pm) begin
        min_pm = acc[i];
        best   = 2'(i);
      end
    end

    for (int i = 0; i < 4; i++) begin
      pm_new[i] = acc[i] - min_pm;
    end
  end

  // NOTE: survivors and metrics are reset explicitly: a restart must decode as
  // a fresh stream from state 0, so no history may leak across reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pm[0]       <= '0;
      pm[1]       <= PM_INIT;
      pm[2]       <= PM_INIT;
      pm[3]       <= PM_INIT;
      for (int i = 0; i < 4; i++) surv[i] <= '0;
      fill        <= '0;
      dec_valid_o <= 1'b0;
      dec_d_o     <= 1'b0;
    end else if (dec_enable_i) begin
      for (int i = 0; i < 4; i++) begin
        pm[i]   <= pm_new[i];
        surv[i] <= surv_new[i][TB_DEPTH-2:0];
      end
      if (fill != FILL_FULL) fill <= fill + 1'b1;
      // Valid from the edge that accepts the TB_DEPTH-th symbol onward.
      dec_valid_o <= (fill >= FILL_LAST);
      dec_d_o     <= surv_new[best][TB_DEPTH-1];
    end
  end

`ifdef VITERBI_METRIC_OUT_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      dec_err_o <= 1'b0;
    end else if (dec_enable_i) begin
      dec_err_o <= (win_bm[best] != 2'b00);
    end
  end
`endif

endmodule

// File: tb/tb_viterbi_codec.sv
// -----------------------------------------------------------------------------
// tb_viterbi_codec
//   Directed self-checking bench for viterbi_codec. Expected encoder symbols
//   come from the generator equations; expected decoded bits are the bench's
//   own input bits delayed by TB_DEPTH-1 accepted symbols.
// -----------------------------------------------------------------------------
module tb_viterbi_codec;

  localparam int TB_DEPTH = 16;
  localparam int PM_W     = 6;

  logic       clk = 1'b0;
  logic       rst;
  logic       enc_enable_i;
  logic       enc_d_i;
  logic       enc_valid_o;
  logic [1:0] enc_d_o;
  logic       dec_enable_i;
  logic [1:0] dec_d_i;
  logic       dec_valid_o;
  logic       dec_d_o;
`ifdef VITERBI_METRIC_OUT_EN
  logic       dec_err_o;
`endif

  viterbi_codec #(.TB_DEPTH(TB_DEPTH), .PM_W(PM_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .enc_enable_i (enc_enable_i),
    .enc_d_i      (enc_d_i),
    .enc_valid_o  (enc_valid_o),
    .enc_d_o      (enc_d_o),
    .dec_enable_i (dec_enable_i),
    .dec_d_i      (dec_d_i),
    .dec_valid_o  (dec_valid_o),
    .dec_d_o      (dec_d_o)
`ifdef VITERBI_METRIC_OUT_EN
    ,
    .dec_err_o    (dec_err_o)
`endif
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Bench-side model state.
  logic [1:0] msr;
  int         accepted;
  logic       hist[$];
  logic       exp_valid;
  logic       exp_d;
  logic       exp_known;
  logic       burst_mode;
  int         burst_off;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset with the decoder enabled on a non-zero symbol to show reset wins.
  task automatic do_reset();
    rst          = 1'b0;
    enc_enable_i = 1'b1;
    enc_d_i      = 1'b1;
    dec_enable_i = 1'b1;
    dec_d_i      = 2'b11;
    tick();
    rst          = 1'b1;
    enc_enable_i = 1'b0;
    enc_d_i      = 1'b0;
    dec_enable_i = 1'b0;
    dec_d_i      = 2'b00;
    msr       = 2'b00;
    accepted  = 0;
    hist.delete();
    exp_valid = 1'b0;
    exp_d     = 1'b0;
    exp_known = 1'b1;
    check("rst_enc_valid", 16'(enc_valid_o), 16'd0);
    check("rst_enc_d",     16'(enc_d_o),     16'd0);
    check("rst_dec_valid", 16'(dec_valid_o), 16'd0);
    check("rst_dec_d",     16'(dec_d_o),     16'd0);
  endtask

  // One clock: bit b into the encoder and its clean symbol (xor flip) into the
  // decoder, both gated by en; then check encoder and decoder outputs.
  task automatic step(input logic b, input logic en, input logic [1:0] flip);
    logic [1:0] sym;
    int         e;
    sym          = {b ^ msr[1] ^ msr[0], b ^ msr[0]};
    enc_enable_i = en;
    enc_d_i      = b;
    dec_enable_i = en;
    dec_d_i      = sym ^ flip;
    tick();
    check("enc_valid", 16'(enc_valid_o), 16'(en));
    if (en) begin
      msr = {b, msr[1]};
      check("enc_sym", 16'(enc_d_o), 16'(sym));
      hist.push_back(b);
      accepted++;
      e = accepted - 1;
      exp_valid = (accepted >= TB_DEPTH);
      if (exp_valid) begin
        exp_d     = hist[accepted - TB_DEPTH];
        exp_known = !(burst_mode && e >= burst_off && ((e - burst_off) % 32) < 18);
      end
    end
    check("dec_valid", 16'(dec_valid_o), 16'(exp_valid));
    if (exp_valid && exp_known) check("dec_bit", 16'(dec_d_o), 16'(exp_d));
`ifdef VITERBI_METRIC_OUT_EN
    if (!burst_mode) check("dec_err", 16'(dec_err_o), 16'd0);
`endif
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int mn;
    rst          = 1'b0;
    enc_enable_i = 1'b0;
    enc_d_i      = 1'b0;
    dec_enable_i = 1'b0;
    dec_d_i      = 2'b00;
    burst_mode   = 1'b0;
    burst_off    = 0;

    // Reset state.
    do_reset();

    // Encoder impulse 1,0,0 -> 11,10,11; gap holds; then 0 -> 00.
    enc_enable_i = 1'b1; enc_d_i = 1'b1; tick();
    check("imp0_valid", 16'(enc_valid_o), 16'd1);
    check("imp0_sym",   16'(enc_d_o),     16'b11);
    enc_d_i = 1'b0; tick();
    check("imp1_sym",   16'(enc_d_o),     16'b10);
    tick();
    check("imp2_sym",   16'(enc_d_o),     16'b11);
    enc_enable_i = 1'b0; tick();
    check("imp_gap_valid", 16'(enc_valid_o), 16'd0);
    check("imp_gap_hold",  16'(enc_d_o),     16'b11);
    enc_enable_i = 1'b1; tick();
    check("imp3_valid", 16'(enc_valid_o), 16'd1);
    check("imp3_sym",   16'(enc_d_o),     16'b00);
    enc_enable_i = 1'b0;
    check("imp_dec_idle", 16'(dec_valid_o), 16'd0);

    // Clean loopback, 256 random bits.
    do_reset();
    for (int i = 0; i < 256; i++) step(1'($urandom_range(0, 1)), 1'b1, 2'b00);

    // Bursts of 4 bit[0] flips every 32 symbols, 28 clean symbols between.
    do_reset();
    burst_mode = 1'b1;
    burst_off  = int'($urandom_range(0, 28));
    for (int i = 0; i < 256; i++) begin
      step(1'($urandom_range(0, 1)), 1'b1,
           (i >= burst_off && ((i - burst_off) % 32) < 4) ? 2'b01 : 2'b00);
    end
    burst_mode = 1'b0;
    exp_known  = 1'b1;

    // 50% enable duty: decoded sequence identical, outputs hold in gaps.
    do_reset();
    for (int i = 0; i < 320; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'b00);
    end

    // Reset after 100 symbols, then a fresh stream decodes from state 0.
    do_reset();
    for (int i = 0; i < 100; i++) step(1'($urandom_range(0, 1)), 1'b1, 2'b00);
    do_reset();
    for (int i = 0; i < 48; i++) step(1'($urandom_range(0, 1)), 1'b1, 2'b00);

    // Long run of all-ones symbols: the best metric stays normalized to 0.
    do_reset();
    dec_enable_i = 1'b1;
    dec_d_i      = 2'b11;
    for (int i = 0; i < 2000; i++) begin
      tick();
      mn = 1 << PM_W;
      for (int s = 0; s < 4; s++) if (int'(dut.pm[s]) < mn) mn = int'(dut.pm[s]);
      check("pm_best_zero", 16'(mn), 16'd0);
    end
    check("ones_dec_valid", 16'(dec_valid_o), 16'd1);
    dec_enable_i = 1'b0;
    dec_d_i      = 2'b00;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
